// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: direction codes, FSM states,
// and the helper that finds the opposite direction.
package snake_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SCAN,
        ST_MOVE,
        ST_DEAD
    } state_t;

    // Opposite directions differ only in the low bit.
    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Candidate head cell for one move. Build with SNAKE_WRAP_EN defined to wrap
// at the grid edges instead of reporting a wall hit.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int POS_W  = 10,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 24
) (
    input  logic [POS_W-1:0] head,
    input  logic [1:0]       dir,
    output logic [POS_W-1:0] nh,
    output logic             wall_hit
);

    localparam logic [POS_W-1:0] W_P      = POS_W'(WIDTH);
    localparam logic [POS_W-1:0] ONE_P    = POS_W'(1);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(HEIGHT - 1);
`ifdef SNAKE_WRAP_EN
    localparam logic [POS_W-1:0] WRAP_V   = POS_W'((HEIGHT - 1) * WIDTH);
`endif

    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;

    assign col = head % W_P;
    assign row = head / W_P;

    always_comb begin
        nh       = head;
        wall_hit = 1'b0;
        case (dir)
            DIR_LEFT: begin
                if (col == '0) begin
`ifdef SNAKE_WRAP_EN
                    nh = head + LAST_COL;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    nh = head - ONE_P;
                end
            end
            DIR_RIGHT: begin
                if (col == LAST_COL) begin
`ifdef SNAKE_WRAP_EN
                    nh = head - LAST_COL;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    nh = head + ONE_P;
                end
            end
            DIR_UP: begin
                if (row == '0) begin
`ifdef SNAKE_WRAP_EN
                    nh = head + WRAP_V;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    nh = head - W_P;
                end
            end
            default: begin
                if (row == LAST_ROW) begin
`ifdef SNAKE_WRAP_EN
                    nh = col;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    nh = head + W_P;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_mover.sv
// Snake body engine: body list, direction filter, growth and multi-cycle
// self-collision scan. SNAKE_WRAP_EN selects edge wrapping in snake_next_head.
module snake_mover
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int POS_W    = 10,
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 24,
    parameter int LEN_W    = 5,
    parameter int INIT_LEN = 3,
    parameter int INIT_POS = 400
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic                     grow,
    input  logic                     dir_valid,
    input  logic [1:0]               dir_req,
    output logic [MAX_LEN*POS_W-1:0] body,
    output logic [LEN_W-1:0]         len,
    output logic [1:0]               dir,
    output logic                     busy,
    output logic                     done,
    output logic                     dead
);

    state_t           state, state_nx;
    logic [POS_W-1:0] seg [MAX_LEN];
    logic [POS_W-1:0] nh, nh_c, seg_k;
    logic             wall_hit;
    logic [1:0]       pend_dir;
    logic             grow_l;
    logic [LEN_W-1:0] k, scan_lim;
    logic             accept;

    snake_next_head #(
        .POS_W (POS_W),
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_next_head (
        .head    (seg[0]),
        .dir     (dir),
        .nh      (nh_c),
        .wall_hit(wall_hit)
    );

    // done also marks the final busy cycle, so a step there is dropped.
    assign accept   = step && (state == ST_IDLE) && !done;
    assign busy     = ((state != ST_IDLE) && !dead) || done;
    assign scan_lim = grow_l ? len : len - LEN_W'(1);

    always_comb begin
        seg_k = seg[0];
        for (int i = 0; i < MAX_LEN; i++) begin
            if (k == LEN_W'(i)) seg_k = seg[i];
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign body[g*POS_W +: POS_W] = seg[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_CALC;
            ST_CALC: begin
                if (wall_hit)             state_nx = ST_DEAD;
                else if (scan_lim == '0)  state_nx = ST_MOVE;
                else                      state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                if (seg_k == nh)                      state_nx = ST_DEAD;
                else if (k + LEN_W'(1) == scan_lim)   state_nx = ST_MOVE;
            end
            ST_MOVE: state_nx = ST_IDLE;
            default: state_nx = ST_DEAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++)
                seg[i] <= POS_W'(INIT_POS - ((i < INIT_LEN) ? i : INIT_LEN - 1));
            len      <= LEN_W'(INIT_LEN);
            dir      <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            grow_l   <= 1'b0;
            nh       <= '0;
            k        <= '0;
            done     <= 1'b0;
            dead     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dir_valid) pend_dir <= dir_req;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dir    <= (pend_dir == reverse_of(dir)) ? dir : pend_dir;
                        // Growth at full length is dropped here, so the scan
                        // and the move both treat it as a plain move.
                        grow_l <= grow && (len < LEN_W'(MAX_LEN));
                    end
                end
                ST_CALC: begin
                    nh <= nh_c;
                    k  <= '0;
                end
                ST_SCAN: k <= k + LEN_W'(1);
                ST_MOVE: begin
                    for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
                    seg[0] <= nh;
                    if (grow_l) len <= len + LEN_W'(1);
                    done <= 1'b1;
                end
                default: begin
                    if (!dead) begin
                        dead <= 1'b1;
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover: a reference model predicts each move,
// the prediction is queued at step time and checked when done pulses.
module tb_snake_mover;

    localparam int MAX_LEN  = 16;
    localparam int POS_W    = 10;
    localparam int WIDTH    = 32;
    localparam int HEIGHT   = 24;
    localparam int LEN_W    = 5;
    localparam int INIT_LEN = 3;
    localparam int INIT_POS = 400;
    localparam int BW       = MAX_LEN * POS_W;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, step, grow, dir_valid;
    logic [1:0]       dir_req;
    logic [BW-1:0]    body;
    logic [LEN_W-1:0] len;
    logic [1:0]       dir;
    logic             busy, done, dead;

    always #5 clk = ~clk;

    snake_mover #(
        .MAX_LEN (MAX_LEN),
        .POS_W   (POS_W),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .LEN_W   (LEN_W),
        .INIT_LEN(INIT_LEN),
        .INIT_POS(INIT_POS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .grow     (grow),
        .dir_valid(dir_valid),
        .dir_req  (dir_req),
        .body     (body),
        .len      (len),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .dead     (dead)
    );

    typedef struct {
        int            lat;
        logic [BW-1:0] body;
        int            len;
        logic [1:0]    dir;
        logic          dead;
    } exp_t;

    exp_t       sb[$];
    int         m_seg[MAX_LEN];
    int         m_len;
    logic [1:0] m_dir, m_pend;
    logic       m_dead;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack_body();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_LEN; i++) v[i*POS_W +: POS_W] = POS_W'(m_seg[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_LEN; i++)
            m_seg[i] = INIT_POS - ((i < INIT_LEN) ? i : INIT_LEN - 1);
        m_len  = INIT_LEN;
        m_dir  = 2'b01;
        m_pend = 2'b01;
        m_dead = 1'b0;
    endtask

    task automatic model_step(input logic g);
        exp_t       e;
        logic [1:0] rev;
        int         head, col, row, nh, rng, hit;
        logic       wall, geff;
        case (m_dir)
            2'b00:   rev = 2'b01;
            2'b01:   rev = 2'b00;
            2'b10:   rev = 2'b11;
            default: rev = 2'b10;
        endcase
        if (m_pend != rev) m_dir = m_pend;
        head = m_seg[0];
        col  = head % WIDTH;
        row  = head / WIDTH;
        wall = 1'b0;
        nh   = head;
        case (m_dir)
            2'b00: if (col == 0) begin
                       if (WRAP) nh = row * WIDTH + WIDTH - 1; else wall = 1'b1;
                   end else nh = head - 1;
            2'b01: if (col == WIDTH - 1) begin
                       if (WRAP) nh = row * WIDTH; else wall = 1'b1;
                   end else nh = head + 1;
            2'b10: if (row == 0) begin
                       if (WRAP) nh = (HEIGHT - 1) * WIDTH + col; else wall = 1'b1;
                   end else nh = head - WIDTH;
            default: if (row == HEIGHT - 1) begin
                       if (WRAP) nh = col; else wall = 1'b1;
                   end else nh = head + WIDTH;
        endcase
        geff = g && (m_len < MAX_LEN);
        if (wall) begin
            e.lat  = 2;
            m_dead = 1'b1;
        end else begin
            rng = geff ? m_len : m_len - 1;
            hit = -1;
            for (int j = 0; j < rng; j++) begin
                if (hit < 0 && m_seg[j] == nh) hit = j;
            end
            if (hit >= 0) begin
                e.lat  = 3 + hit;
                m_dead = 1'b1;
            end else begin
                e.lat = 2 + rng;
                for (int i = MAX_LEN - 1; i > 0; i--) m_seg[i] = m_seg[i-1];
                m_seg[0] = nh;
                if (geff) m_len++;
            end
        end
        e.body = pack_body();
        e.len  = m_len;
        e.dir  = m_dir;
        e.dead = m_dead;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_body"}, body, pack_body());
        check_val({tag, "_len"},  BW'(len), BW'(m_len));
        check_val({tag, "_dir"},  BW'(dir), BW'(m_dir));
        check_val({tag, "_busy"}, BW'(busy), BW'(0));
        check_val({tag, "_done"}, BW'(done), BW'(0));
        check_val({tag, "_dead"}, BW'(dead), BW'(0));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic send_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_req   = d;
        m_pend    = d;
        @(posedge clk); #1;
        dir_valid = 1'b0;
    endtask

    // Called at posedge+1; also fires a second step mid-move that must be dropped.
    task automatic do_step(input logic g);
        exp_t          e;
        int            cnt;
        logic          saw_done;
        logic [BW-1:0] snap;
        if (m_dead) begin
            snap = pack_body();
            step = 1'b1;
            grow = g;
            @(posedge clk); #1;
            step = 1'b0;
            grow = 1'b0;
            saw_done = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
                saw_done |= done;
            end
            check_val("dead_step_done", BW'(saw_done), BW'(0));
            check_val("dead_step_body", body, snap);
            check_val("dead_step_dead", BW'(dead), BW'(1));
            return;
        end
        model_step(g);
        step = 1'b1;
        grow = g;
        @(posedge clk); #1;
        step = 1'b0;
        grow = 1'b0;
        cnt  = 0;
        while (!done && cnt < 40) begin
            step = (cnt == 1);
            @(posedge clk); #1;
            cnt++;
        end
        step = 1'b0;
        if (!done) check_val("done_timeout", BW'(0), BW'(1));
        e = sb.pop_front();
        check_val("latency", BW'(cnt), BW'(e.lat));
        check_val("body",    body, e.body);
        check_val("len",     BW'(len), BW'(e.len));
        check_val("dir",     BW'(dir), BW'(e.dir));
        check_val("dead",    BW'(dead), BW'(e.dead));
        check_val("busy_at_done", BW'(busy), BW'(1));
        @(posedge clk); #1;
        check_val("done_pulse", BW'(done), BW'(0));
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; step = 1'b0; grow = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_reset("reset");

        // Plain move right, then a reverse request that must be discarded.
        do_step(1'b0);
        check_val("head_401", BW'(body[POS_W-1:0]), BW'(401));
        send_dir(2'b00);
        do_step(1'b0);
        check_val("head_402", BW'(body[POS_W-1:0]), BW'(402));

        // Growth 3 -> 8.
        repeat (5) do_step(1'b1);
        check_val("len_8", BW'(len), BW'(8));

        // Run to the right edge, then into the wall (or wrap), then a further step.
        while (m_seg[0] % WIDTH != WIDTH - 1) do_step(1'b0);
        do_step(1'b0);
        do_step(1'b0);

        // Coil a length-5 snake into its own segment 3.
        apply_reset();
        do_step(1'b1);
        do_step(1'b1);
        send_dir(2'b11);
        do_step(1'b0);
        send_dir(2'b00);
        do_step(1'b0);
        send_dir(2'b10);
        do_step(1'b0);
        check_val("coil_dead", BW'(dead), BW'(1));

        // Reset while the scan is running.
        apply_reset();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset("scan_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        check_val("scan_rst_no_done", BW'(saw_done), BW'(0));
        check_reset("scan_rst_after");

        // Fill to MAX_LEN; a further grow is ignored.
        apply_reset();
        repeat (MAX_LEN - INIT_LEN) do_step(1'b1);
        check_val("len_max", BW'(len), BW'(MAX_LEN));
        do_step(1'b1);
        check_val("len_max_hold", BW'(len), BW'(MAX_LEN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_mover.md
# snake_mover

Parametrised snake body engine for the VGA snake game. It holds the full body position list internally, advances it one cell per `step` request, and filters direction requests so the snake cannot reverse into itself. It grows on request, detects wall and self collisions with a multi-cycle scan, and reports a sticky `dead` flag to the game controller. It sits between the keyboard/direction decoder and the renderer/food logic.

## Interface
- `MAX_LEN`, 16: maximum segment count.
- `POS_W`, 10: bits per linear cell index (`row*WIDTH+col`).
- `WIDTH`, 32: grid columns.
- `HEIGHT`, 24: grid rows.
- `LEN_W`, 5: length counter width; must hold `MAX_LEN`.
- `INIT_LEN`, 3: length after reset; 1..`MAX_LEN`.
- `INIT_POS`, 400: head cell after reset; requires `INIT_POS%WIDTH >= INIT_LEN-1`.

Ports:
- `clk` input, 1: clock.
- `rst` input, 1: reset; asynchronous, active-high.
- `step` input, 1: one-cycle move request; accepted only when `busy=0` and `dead=0`.
- `grow` input, 1: sampled with an accepted `step`; that move does not drop the tail.
- `dir_valid` input, 1: direction request strobe.
- `dir_req` input, 2: encoding 00 left, 01 right, 10 up, 11 down.
- `body` output, `MAX_LEN*POS_W`: segment i at `[i*POS_W +: POS_W]`; segment 0 is the head.
- `len` output, `LEN_W`: current length.
- `dir` output, 2: committed direction.
- `busy` output, 1: move in progress.
- `done` output, 1: one-cycle pulse when a move completes or a death is detected.
- `dead` output, 1: sticky collision flag.

## Operation
- Reset values: segment i = `INIT_POS-i` for i < `INIT_LEN`; remaining segments = `INIT_POS-(INIT_LEN-1)`. `len`=`INIT_LEN`, `dir`=01, `busy`=0, `done`=0, `dead`=0, state IDLE, pending direction = 01.
- Pending direction register:
  - Loaded from `dir_req` on any `dir_valid` cycle; the latest request wins.
  - Committed to `dir` when a `step` is accepted.
  - A request that is the exact reverse of `dir` is discarded at commit, and `dir` is kept.
- FSM states: IDLE, CALC, SCAN, MOVE, DEAD.
- IDLE → CALC on accepted `step`. The committed direction and `grow` are latched.
- CALC (1 cycle): compute candidate head `nh`.
  - Left: `col==0` is a wall hit, else `nh = head-1`.
  - Right: `col==WIDTH-1` is a wall hit, else `nh = head+1`.
  - Up: `row==0` is a wall hit, else `nh = head-WIDTH`.
  - Down: `row==HEIGHT-1` is a wall hit, else `nh = head+WIDTH`.
  - Wall hit → DEAD. Otherwise → SCAN with index k=0.
- SCAN: compare `nh` with segment k, one segment per cycle.
  - Scan range is `k < len-1` when not growing, `k < len` when growing; the tail vacates its cell unless growing.
  - Match → DEAD. Range exhausted → MOVE.
- MOVE (1 cycle):
  - Segment i ← segment i-1 for 1 ≤ i < `MAX_LEN`; segment 0 ← `nh`.
  - If growing and `len<MAX_LEN`, then `len` increments. At `MAX_LEN`, `grow` is ignored and the move is plain.
  - Pulse `done`, then return to IDLE.
- DEAD: on entry, pulse `done` and set `dead`=1. `body` is frozen. The block stays here until `rst`; a `step` in DEAD is ignored.
- Reset during any state: everything returns to reset values immediately, and no partial shift is ever visible.

## Timing
- `busy`=1 from the cycle after `step` is accepted until the `done` cycle inclusive.
- Move latency from the `step` edge to the `done` cycle: 1 (CALC) + scan count + 1 (MOVE).
  - Non-grow scan count = `len-1`.
  - Grow scan count = `len`.
  - Example: `len`=3, no grow → `done` 4 cycles after `step`.
- Wall death: `done` and `dead` 2 cycles after `step`.
- Self collision at k: `done` and `dead` 2+k+1 cycles after `step`.
- `body`/`len` update on the same edge that raises `done`.
- `step` while `busy` is dropped, not queued.
- `dir_valid` is accepted in every state, including during `busy`.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Walls wrap around. Left at col 0 → col `WIDTH-1`; right at col `WIDTH-1` → col 0; up at row 0 → row `HEIGHT-1`; down at row `HEIGHT-1` → row 0. Row or column is preserved accordingly.
  - Wall death never occurs; only self collision kills.
- `SNAKE_WRAP_EN` undefined: wall hits kill, as in CALC.

## Structure
- `snake_pkg`: direction encodings (`DIR_LEFT`…`DIR_DOWN`), FSM state enum, and a `reverse_of` function.
- Sub-module `snake_next_head`: combinational head/direction → `nh`, `wall_hit`; honours `SNAKE_WRAP_EN`.
- The top level holds the body array, length counter, scan counter and FSM.

## Test plan
- Reset, `step` with no `dir_valid` → head 401, body {401,400,399}, `done` 4 cycles after `step`.
- `dir_req`=00 while moving right → ignored; `dir` stays 01 and head 402 after the next step.
- Head at col 31 moving right, macro off → `dead`=1 and `done` 2 cycles after `step`; later steps change nothing. Macro on → head becomes col 0 of the same row.
- `grow`=1 on 5 steps → `len` 3→8. Drive to `MAX_LEN`, then `grow` again → `len` stays 16.
- Coil a length-5 snake down, left, up into segment 3 → `dead` at cycle 2+3+1 after `step`.
- Assert `rst` during SCAN → body/`len`/`dir` at reset values next cycle, `busy`=0, no `done` pulse.
